// File: rtl/pic_prio.sv
// pic_prio - fixed-priority, nesting interrupt controller for the internal CPU bus.
//
// Accepts NUM_IRQ edge-triggered request lines. IRQ0 has the highest priority.
// Provides a mask register (IMR), a request register (IRR) and an in-service
// register (ISR). Software can end an interrupt with a non-specific or a
// specific EOI. The vector is delivered over a two-cycle INTA sequence.
//
// Optional feature: define PIC_AUTO_EOI_EN to make the second INTA clear the
// in-service bit of the line it acknowledges (automatic EOI).
//
// Ports:
//   iClk     system clock
//   iRstN    asynchronous active-low reset
//   iIrq     raw request lines, asynchronous to iClk
//   iAddr    CPU address
//   iData    CPU write data
//   iWr      IO write strobe, one-cycle pulse
//   iRd      IO read strobe, one-cycle pulse
//   iIntAck  INTA bus-cycle strobe, one pulse per INTA cycle
//   oInt     registered interrupt request to the CPU
//   oSel     selects oData onto the CPU read-data mux
//   oData    read data or interrupt vector

module pic_prio #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [7:0]  VEC_BASE = 8'h08,
  parameter logic [19:0] IO_BASE  = 20'h00020
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic [19:0]        iAddr,
  input  logic [7:0]         iData,
  input  logic               iWr,
  input  logic               iRd,
  input  logic               iIntAck,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData
);

  typedef enum logic {IDLE, ACK2} state_t;

  localparam logic [19:0] ADDR_MASK = IO_BASE + 20'd1;
  localparam logic [2:0]  LAST_IRQ  = 3'(NUM_IRQ - 1);

  state_t             r_state;
  logic [2:0]         r_winner;
  logic               r_spur;
  logic               r_int;
  logic [NUM_IRQ-1:0] r_sync1, r_sync2, r_syncPrev;
  logic [NUM_IRQ-1:0] r_irr, r_isr, r_imr;
  logic               r_rdIsr;
  logic               r_sel;
  logic [7:0]         r_data;

  logic [NUM_IRQ-1:0] w_edge, w_pend;
  logic [NUM_IRQ-1:0] w_irrClr, w_isrClr, w_isrSet;
  logic               w_candValid, w_isrAny, w_intReq;
  logic [2:0]         w_cand, w_isrTop, w_winnerNext, w_vecIdx;
  logic               w_selCmd, w_selMask, w_wrCmd, w_wrMask;
  logic               w_nsEoi, w_sEoi, w_ack1, w_ack2;
  logic [7:0]         w_vec, w_irr8, w_isr8, w_imr8, w_rdData;

  assign w_edge = r_sync2 & ~r_syncPrev;
  assign w_pend = r_irr & ~r_imr;

  // Lowest-index eligible request, and lowest-index line currently in service.
  always_comb begin
    w_candValid = 1'b0;
    w_cand      = 3'd0;
    w_isrAny    = 1'b0;
    w_isrTop    = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_candValid = 1'b1;
        w_cand      = 3'(i);
      end
      if (r_isr[i]) begin
        w_isrAny = 1'b1;
        w_isrTop = 3'(i);
      end
    end
  end

  assign w_intReq     = w_candValid && (!w_isrAny || (w_cand < w_isrTop));
  assign w_winnerNext = w_candValid ? w_cand : LAST_IRQ;

  assign w_selCmd  = (iAddr == IO_BASE);
  assign w_selMask = (iAddr == ADDR_MASK);
  assign w_wrCmd   = iWr && w_selCmd;
  assign w_wrMask  = iWr && w_selMask;
  assign w_nsEoi   = w_wrCmd && (iData == 8'h20) && w_isrAny;
  assign w_sEoi    = w_wrCmd && (iData[7:3] == 5'b01100) && (int'(iData[2:0]) < NUM_IRQ);
  assign w_ack1    = iIntAck && (r_state == IDLE);
  assign w_ack2    = iIntAck && (r_state == ACK2);

  // Per-line set/clear masks; built with compares so the index width never
  // has to match a narrow NUM_IRQ.
  always_comb begin
    w_irrClr = '0;
    w_isrClr = '0;
    w_isrSet = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_ack1 && w_candValid && (w_cand == 3'(i))) begin
        w_irrClr[i] = 1'b1;
        w_isrSet[i] = 1'b1;
      end
      if (w_nsEoi && (w_isrTop == 3'(i))) w_isrClr[i] = 1'b1;
      if (w_sEoi && (iData[2:0] == 3'(i))) w_isrClr[i] = 1'b1;
`ifdef PIC_AUTO_EOI_EN
      if (w_ack2 && !r_spur && (r_winner == 3'(i))) w_isrClr[i] = 1'b1;
`endif
    end
  end

  // Two-flop synchronizer plus the previous-value flop for edge detection.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_syncPrev <= '0;
    end else begin
      r_sync1    <= iIrq;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  // A new edge beats the acknowledge clear on the same line. EOI clears are
  // applied before the acknowledge sets the in-service bit.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_irr   <= '0;
      r_isr   <= '0;
      r_imr   <= '1;
      r_rdIsr <= 1'b0;
    end else begin
      r_irr <= (r_irr & ~w_irrClr) | w_edge;
      r_isr <= (r_isr & ~w_isrClr) | w_isrSet;
      if (w_wrMask) r_imr <= iData[NUM_IRQ-1:0];
      if (w_wrCmd && (iData == 8'h0A)) r_rdIsr <= 1'b0;
      if (w_wrCmd && (iData == 8'h0B)) r_rdIsr <= 1'b1;
    end
  end

  // INTA sequencer. The winner is frozen on the first INTA; with nothing
  // eligible the sequence is spurious and returns the lowest-priority vector.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state  <= IDLE;
      r_winner <= 3'd0;
      r_spur   <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iIntAck) begin
            r_state  <= ACK2;
            r_winner <= w_winnerNext;
            r_spur   <= !w_candValid;
            r_int    <= 1'b0;
          end else begin
            r_int <= w_intReq;
          end
        end
        ACK2: begin
          r_int <= 1'b0;
          if (iIntAck) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_int   <= 1'b0;
        end
      endcase
    end
  end

  assign w_vecIdx = (r_state == IDLE) ? w_winnerNext : r_winner;
  assign w_vec    = VEC_BASE + {5'd0, w_vecIdx};

  always_comb begin
    w_irr8 = '0;
    w_isr8 = '0;
    w_imr8 = '0;
    w_irr8[NUM_IRQ-1:0] = r_irr;
    w_isr8[NUM_IRQ-1:0] = r_isr;
    w_imr8[NUM_IRQ-1:0] = r_imr;
    w_rdData = w_selMask ? w_imr8 : (r_rdIsr ? w_isr8 : w_irr8);
  end

  // Bus output holds until the next strobe; a non-matching strobe clears it.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_sel  <= 1'b0;
      r_data <= 8'h00;
    end else if (iIntAck) begin
      r_sel  <= 1'b1;
      r_data <= w_vec;
    end else if (iRd && (w_selCmd || w_selMask)) begin
      r_sel  <= 1'b1;
      r_data <= w_rdData;
    end else if (iRd || iWr) begin
      r_sel  <= 1'b0;
      r_data <= 8'h00;
    end
  end

  assign oInt  = r_int;
  assign oSel  = r_sel;
  assign oData = r_data;

endmodule

// File: tb/tb_pic_prio.sv
// tb_pic_prio - directed self-checking bench for pic_prio (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_pic_prio;

  localparam logic [19:0] IO_CMD  = 20'h00020;
  localparam logic [19:0] IO_MASK = 20'h00021;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic [7:0] iIrq;
  logic [19:0] iAddr;
  logic [7:0] iData;
  logic       iWr, iRd, iIntAck;
  logic       oInt, oSel;
  logic [7:0] oData;

  int checks   = 0;
  int failures = 0;

  logic       s;
  logic [7:0] d;

  pic_prio dut (
    .iClk(iClk), .iRstN(iRstN), .iIrq(iIrq), .iAddr(iAddr), .iData(iData),
    .iWr(iWr), .iRd(iRd), .iIntAck(iIntAck),
    .oInt(oInt), .oSel(oSel), .oData(oData)
  );

  always #50 iClk = ~iClk;

  task automatic cycles(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic ioWrite(input logic [19:0] a, input logic [7:0] v);
    iAddr = a; iData = v; iWr = 1'b1;
    @(negedge iClk);
    iWr = 1'b0;
  endtask

  task automatic ioRead(input logic [19:0] a, output logic sel, output logic [7:0] v);
    iAddr = a; iRd = 1'b1;
    @(negedge iClk);
    iRd = 1'b0;
    sel = oSel; v = oData;
  endtask

  task automatic intAck(output logic sel, output logic [7:0] v);
    iIntAck = 1'b1;
    @(negedge iClk);
    iIntAck = 1'b0;
    sel = oSel; v = oData;
  endtask

  task automatic test_reset;
    iRstN = 1'b0; iIrq = '0; iAddr = '0; iData = '0;
    iWr = 1'b0; iRd = 1'b0; iIntAck = 1'b0;
    cycles(2);
    checks++; if ({oInt, oSel, oData} !== 10'd0) begin failures++; $display("[TB] FAIL reset_out: got %b want 0", {oInt, oSel, oData}); end
    iRstN = 1'b1;
    cycles(1);
    ioRead(IO_MASK, s, d);
    checks++; if ({s, d} !== 9'h1FF) begin failures++; $display("[TB] FAIL reset_imr: got sel=%b data=%h want sel=1 data=ff", s, d); end
  endtask

  task automatic test_basic;
    ioWrite(IO_MASK, 8'hFC);
    iIrq[0] = 1'b1;
    cycles(3);
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL basic_lat3: got %b want 0", oInt); end
    cycles(1);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL basic_lat4: got %b want 1", oInt); end
    intAck(s, d);
    checks++; if ({s, d} !== 9'h108) begin failures++; $display("[TB] FAIL basic_ack1: got sel=%b data=%h want sel=1 data=08", s, d); end
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL basic_int_ack2: got %b want 0", oInt); end
    intAck(s, d);
    checks++; if ({s, d} !== 9'h108) begin failures++; $display("[TB] FAIL basic_ack2: got sel=%b data=%h want sel=1 data=08", s, d); end
    ioWrite(IO_CMD, 8'h0B);
    ioRead(IO_CMD, s, d);
`ifdef PIC_AUTO_EOI_EN
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL basic_isr: got %h want 00", d); end
`else
    checks++; if (d !== 8'h01) begin failures++; $display("[TB] FAIL basic_isr: got %h want 01", d); end
`endif
    ioWrite(IO_CMD, 8'h20);
    ioRead(IO_CMD, s, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL basic_isr_eoi: got %h want 00", d); end
    ioWrite(IO_CMD, 8'h0A);
    iIrq = '0;
    cycles(3);
  endtask

  task automatic test_simultaneous;
    ioWrite(IO_MASK, 8'h00);
    iIrq[1:0] = 2'b11;
    cycles(5);
    intAck(s, d);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h108) begin failures++; $display("[TB] FAIL simul_first: got sel=%b data=%h want sel=1 data=08", s, d); end
    cycles(3);
`ifdef PIC_AUTO_EOI_EN
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL simul_hold: got %b want 1", oInt); end
`else
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL simul_hold: got %b want 0", oInt); end
`endif
    ioWrite(IO_CMD, 8'h20);
    cycles(1);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL simul_after_eoi: got %b want 1", oInt); end
    intAck(s, d);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h109) begin failures++; $display("[TB] FAIL simul_second: got sel=%b data=%h want sel=1 data=09", s, d); end
    ioWrite(IO_CMD, 8'h20);
    iIrq = '0;
    cycles(3);
  endtask

  task automatic test_nesting;
    iIrq[1] = 1'b1;
    cycles(5);
    intAck(s, d);
    intAck(s, d);
    iIrq[0] = 1'b1;
    cycles(5);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL nest_int: got %b want 1", oInt); end
    intAck(s, d);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h108) begin failures++; $display("[TB] FAIL nest_vec: got sel=%b data=%h want sel=1 data=08", s, d); end
    ioWrite(IO_CMD, 8'h20);
    ioWrite(IO_CMD, 8'h20);
    iIrq = '0;
    cycles(3);
    iIrq[1] = 1'b1;
    cycles(5);
    intAck(s, d);
    intAck(s, d);
    iIrq[2] = 1'b1;
    cycles(5);
`ifdef PIC_AUTO_EOI_EN
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL nest_low_blocked: got %b want 1", oInt); end
`else
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL nest_low_blocked: got %b want 0", oInt); end
`endif
    ioWrite(IO_CMD, 8'h61);
    cycles(1);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL nest_low_after_eoi: got %b want 1", oInt); end
    intAck(s, d);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h10A) begin failures++; $display("[TB] FAIL nest_low_vec: got sel=%b data=%h want sel=1 data=0a", s, d); end
    ioWrite(IO_CMD, 8'h20);
    iIrq = '0;
    cycles(3);
  endtask

  task automatic test_mask;
    ioWrite(IO_MASK, 8'h08);
    iIrq[3] = 1'b1;
    cycles(5);
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL mask_int: got %b want 0", oInt); end
    ioWrite(IO_CMD, 8'h0A);
    ioRead(IO_CMD, s, d);
    checks++; if ({s, d} !== 9'h108) begin failures++; $display("[TB] FAIL mask_irr: got sel=%b data=%h want sel=1 data=08", s, d); end
    ioWrite(IO_MASK, 8'h00);
    checks++; if (oInt !== 1'b0) begin failures++; $display("[TB] FAIL mask_unmask_edge: got %b want 0", oInt); end
    cycles(1);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL mask_unmask_next: got %b want 1", oInt); end
    intAck(s, d);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h10B) begin failures++; $display("[TB] FAIL mask_vec: got sel=%b data=%h want sel=1 data=0b", s, d); end
    ioWrite(IO_CMD, 8'h20);
    iIrq = '0;
    cycles(3);
  endtask

  task automatic test_spurious;
    iIrq[4] = 1'b1;
    cycles(5);
    checks++; if (oInt !== 1'b1) begin failures++; $display("[TB] FAIL spur_raise: got %b want 1", oInt); end
    ioWrite(IO_MASK, 8'hFF);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h10F) begin failures++; $display("[TB] FAIL spur_ack1: got sel=%b data=%h want sel=1 data=0f", s, d); end
    intAck(s, d);
    checks++; if ({s, d} !== 9'h10F) begin failures++; $display("[TB] FAIL spur_ack2: got sel=%b data=%h want sel=1 data=0f", s, d); end
    ioWrite(IO_CMD, 8'h0B);
    ioRead(IO_CMD, s, d);
    checks++; if (d !== 8'h00) begin failures++; $display("[TB] FAIL spur_isr: got %h want 00", d); end
    ioWrite(IO_CMD, 8'h0A);
    ioRead(IO_CMD, s, d);
    checks++; if (d !== 8'h10) begin failures++; $display("[TB] FAIL spur_irr: got %h want 10", d); end
    iIrq = '0;
  endtask

  task automatic test_reset_mid_ack;
    ioWrite(IO_MASK, 8'h00);
    cycles(2);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h10C) begin failures++; $display("[TB] FAIL rst_ack1: got sel=%b data=%h want sel=1 data=0c", s, d); end
    #10 iRstN = 1'b0;
    #1;
    checks++; if ({oInt, oSel, oData} !== 10'd0) begin failures++; $display("[TB] FAIL rst_async: got %b want 0", {oInt, oSel, oData}); end
    @(negedge iClk);
    intAck(s, d);
    checks++; if ({s, d} !== 9'h000) begin failures++; $display("[TB] FAIL rst_pending_inta: got sel=%b data=%h want sel=0 data=00", s, d); end
    iRstN = 1'b1;
    cycles(1);
    ioRead(IO_MASK, s, d);
    checks++; if ({s, d} !== 9'h1FF) begin failures++; $display("[TB] FAIL rst_imr: got sel=%b data=%h want sel=1 data=ff", s, d); end
    ioRead(IO_CMD, s, d);
    checks++; if ({s, d} !== 9'h100) begin failures++; $display("[TB] FAIL rst_irr: got sel=%b data=%h want sel=1 data=00", s, d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_nesting();
    test_mask();
    test_spurious();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
